// File: rtl/gpio_irq_pkg.sv
// Shared constants for the GPIO input / interrupt front end.
// Register indices, debounce counter width and bus widths.
package gpio_irq_pkg;

  localparam int BUS_AW = 24;
  localparam int BUS_DW = 32;
  localparam int DB_W   = 16;

  localparam logic [2:0] REG_IN       = 3'd0;
  localparam logic [2:0] REG_IRQ_EN   = 3'd1;
  localparam logic [2:0] REG_RISE_EN  = 3'd2;
  localparam logic [2:0] REG_FALL_EN  = 3'd3;
  localparam logic [2:0] REG_PENDING  = 3'd4;
  localparam logic [2:0] REG_DB_LIMIT = 3'd5;

endpackage

// File: rtl/gpio_in_filter.sv
// Per-pin pad synchroniser with optional debounce counter.
// Debounce is built only when GPIO_IRQ_DEBOUNCE_EN is defined.
module gpio_in_filter
  import gpio_irq_pkg::*;
#(
  parameter int SYNC_DEPTH = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pad,
`ifdef GPIO_IRQ_DEBOUNCE_EN
  input  logic [DB_W-1:0] db_limit,
`endif
  output logic            gpio_sync
);

  logic [SYNC_DEPTH-1:0] sync_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_DEPTH-2:0], pad};
  end

`ifdef GPIO_IRQ_DEBOUNCE_EN
  logic            raw;
  logic [DB_W-1:0] cnt;

  assign raw = sync_q[SYNC_DEPTH-1];

  // Output follows raw only after DB_LIMIT+1 consecutive differing cycles
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      gpio_sync <= 1'b0;
    end else if (raw == gpio_sync) begin
      cnt <= '0;
    end else if (cnt == db_limit) begin
      cnt       <= '0;
      gpio_sync <= raw;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign gpio_sync = sync_q[SYNC_DEPTH-1];
`endif

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO input front end: sync, edge detect, pending latch, level irq.
// Optional per-pin debounce via GPIO_IRQ_DEBOUNCE_EN.
module gpio_irq_ctrl
  import gpio_irq_pkg::*;
#(
  parameter int NPINS      = 8,
  parameter int SYNC_DEPTH = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid,
  output logic              ready,
  input  logic              wen,
  input  logic [BUS_AW-1:0] addr,
  input  logic [BUS_DW-1:0] wdata,
  output logic [BUS_DW-1:0] rdata,
  input  logic [NPINS-1:0]  pad_i,
  output logic [NPINS-1:0]  gpio_sync,
  output logic              irq
);

  logic [NPINS-1:0]  prev;
  logic [NPINS-1:0]  irq_en;
  logic [NPINS-1:0]  rise_en;
  logic [NPINS-1:0]  fall_en;
  logic [NPINS-1:0]  pending;
  logic [NPINS-1:0]  evt;
  logic [NPINS-1:0]  w1c_mask;
  logic [2:0]        idx;
  logic              acc;
  logic              wr;
  logic [BUS_DW-1:0] rd_val;
  logic              unused_bus;

`ifdef GPIO_IRQ_DEBOUNCE_EN
  logic [DB_W-1:0]   db_limit;
`endif

  assign idx        = addr[4:2];
  assign acc        = valid & ~ready;
  assign wr         = acc & wen;
  assign unused_bus = ^{addr[23:5], addr[1:0], wdata};

  for (genvar g = 0; g < NPINS; g++) begin : g_pin
    gpio_in_filter #(
      .SYNC_DEPTH(SYNC_DEPTH)
    ) u_filt (
      .clk      (clk),
      .resetn   (resetn),
      .pad      (pad_i[g]),
`ifdef GPIO_IRQ_DEBOUNCE_EN
      .db_limit (db_limit),
`endif
      .gpio_sync(gpio_sync[g])
    );
  end

  assign evt = (gpio_sync & ~prev & rise_en)
             | (~gpio_sync & prev & fall_en);

  assign w1c_mask = (wr && idx == REG_PENDING)
                  ? wdata[NPINS-1:0] : '0;

  always_comb begin
    rd_val = '0;
    unique case (idx)
      REG_IN:      rd_val[NPINS-1:0] = gpio_sync;
      REG_IRQ_EN:  rd_val[NPINS-1:0] = irq_en;
      REG_RISE_EN: rd_val[NPINS-1:0] = rise_en;
      REG_FALL_EN: rd_val[NPINS-1:0] = fall_en;
      REG_PENDING: rd_val[NPINS-1:0] = pending;
`ifdef GPIO_IRQ_DEBOUNCE_EN
      REG_DB_LIMIT: rd_val[DB_W-1:0] = db_limit;
`endif
      default:     rd_val = '0;
    endcase
  end

  // Set wins over a same-cycle W1C clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready   <= 1'b0;
      rdata   <= '0;
      prev    <= '0;
      pending <= '0;
      irq     <= 1'b0;
    end else begin
      ready   <= acc;
      rdata   <= (acc && !wen) ? rd_val : '0;
      prev    <= gpio_sync;
      pending <= (pending & ~w1c_mask) | evt;
      irq     <= |(pending & irq_en);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_en  <= '0;
      rise_en <= '0;
      fall_en <= '0;
`ifdef GPIO_IRQ_DEBOUNCE_EN
      db_limit <= '0;
`endif
    end else if (wr) begin
      unique case (idx)
        REG_IRQ_EN:  irq_en  <= wdata[NPINS-1:0];
        REG_RISE_EN: rise_en <= wdata[NPINS-1:0];
        REG_FALL_EN: fall_en <= wdata[NPINS-1:0];
`ifdef GPIO_IRQ_DEBOUNCE_EN
        REG_DB_LIMIT: db_limit <= wdata[DB_W-1:0];
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench for gpio_irq_ctrl: register table, directed
// corner sequences, and randomized pads against a history-based model.
module tb_gpio_irq_ctrl;
  import gpio_irq_pkg::*;

  localparam int NP = 8;
  localparam int SD = 2;
`ifdef GPIO_IRQ_DEBOUNCE_EN
  localparam int LAT = SD + 1;
`else
  localparam int LAT = SD;
`endif

  logic          clk;
  logic          resetn;
  logic          valid;
  logic          ready;
  logic          wen;
  logic [23:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic [NP-1:0] pad_i;
  logic [NP-1:0] gpio_sync;
  logic          irq;

  gpio_irq_ctrl #(.NPINS(NP), .SYNC_DEPTH(SD)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .valid    (valid),
    .ready    (ready),
    .wen      (wen),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .pad_i    (pad_i),
    .gpio_sync(gpio_sync),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: gpio_sync is the pad value LAT edges ago,
  // an edge is a change between consecutive delayed samples.
  logic [NP-1:0] hist [0:7];
  logic [NP-1:0] m_ien, m_rise, m_fall, m_pend;
  logic [NP-1:0] m_ev, m_clr;
  logic          m_ready, m_irq, m_acc;
  logic [31:0]   m_rdata, m_rdval;
  logic [15:0]   m_db;

  always_comb begin
    m_acc = valid & ~m_ready;
    m_ev  = (hist[LAT-1] & ~hist[LAT] & m_rise)
          | (~hist[LAT-1] & hist[LAT] & m_fall);
    m_clr = '0;
    if (m_acc && wen && addr[4:2] == 3'd4) m_clr = wdata[NP-1:0];
    m_rdval = 32'd0;
    case (addr[4:2])
      3'd0: m_rdval = {24'd0, hist[LAT-1]};
      3'd1: m_rdval = {24'd0, m_ien};
      3'd2: m_rdval = {24'd0, m_rise};
      3'd3: m_rdval = {24'd0, m_fall};
      3'd4: m_rdval = {24'd0, m_pend};
`ifdef GPIO_IRQ_DEBOUNCE_EN
      3'd5: m_rdval = {16'd0, m_db};
`endif
      default: m_rdval = 32'd0;
    endcase
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) hist[i] <= '0;
      m_ien <= '0; m_rise <= '0; m_fall <= '0; m_pend <= '0;
      m_ready <= 1'b0; m_irq <= 1'b0; m_rdata <= '0; m_db <= '0;
    end else begin
      hist[0] <= pad_i;
      for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
      m_ready <= m_acc;
      m_rdata <= (m_acc && !wen) ? m_rdval : 32'd0;
      m_pend  <= (m_pend & ~m_clr) | m_ev;
      m_irq   <= |(m_pend & m_ien);
      if (m_acc && wen) begin
        case (addr[4:2])
          3'd1: m_ien  <= wdata[NP-1:0];
          3'd2: m_rise <= wdata[NP-1:0];
          3'd3: m_fall <= wdata[NP-1:0];
          3'd5: m_db   <= wdata[15:0];
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("rnd_sync", {24'd0, gpio_sync}, {24'd0, hist[LAT-1]});
      chk("rnd_irq", {31'd0, irq}, {31'd0, m_irq});
      chk("rnd_ready", {31'd0, ready}, {31'd0, m_ready});
      chk("rnd_rdata", rdata, m_rdata);
    end
  end

  // Called at a negedge; returns at the negedge of the ready cycle
  task automatic bus(input logic w, input logic [2:0] idx,
                     input logic [31:0] d, output logic [31:0] rd);
    int n = 0;
    valid = 1'b1;
    wen   = w;
    addr  = {19'($urandom), idx, 2'($urandom)};
    wdata = d;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 8);
    chk("bus_ready", {31'd0, ready}, 32'd1);
    rd    = rdata;
    valid = 1'b0;
    wen   = 1'b0;
  endtask

  logic [31:0] dummy;

  task automatic wr(input logic [2:0] idx, input logic [31:0] d);
    bus(1'b1, idx, d, dummy);
  endtask

  task automatic rdreg(input logic [2:0] idx, output logic [31:0] v);
    bus(1'b0, idx, 32'd0, v);
  endtask

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int npulse;
    logic seen;
    resetn = 1'b0; valid = 1'b0; wen = 1'b0;
    addr = '0; wdata = '0; pad_i = 8'h5A;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_sync", {24'd0, gpio_sync}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    pad_i = 8'h00;
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    tbl[0]  = '{REG_IRQ_EN,   32'h0000_00A5, 32'h0000_00A5};
    tbl[1]  = '{REG_RISE_EN,  32'hFFFF_FF3C, 32'h0000_003C};
    tbl[2]  = '{REG_FALL_EN,  32'h0000_0181, 32'h0000_0081};
    tbl[3]  = '{REG_IN,       32'h0000_00FF, 32'h0000_0000};
    tbl[4]  = '{3'd6,         32'hFFFF_FFFF, 32'h0000_0000};
    tbl[5]  = '{3'd7,         32'hFFFF_FFFF, 32'h0000_0000};
`ifdef GPIO_IRQ_DEBOUNCE_EN
    tbl[6]  = '{REG_DB_LIMIT, 32'h0001_2345, 32'h0000_2345};
`else
    tbl[6]  = '{REG_DB_LIMIT, 32'h0001_2345, 32'h0000_0000};
`endif
    tbl[7]  = '{REG_DB_LIMIT, 32'h0000_0000, 32'h0000_0000};
    tbl[8]  = '{REG_PENDING,  32'h0000_00FF, 32'h0000_0000};
    tbl[9]  = '{REG_IRQ_EN,   32'h0000_0000, 32'h0000_0000};
    tbl[10] = '{REG_RISE_EN,  32'h0000_0000, 32'h0000_0000};
    tbl[11] = '{REG_FALL_EN,  32'h0000_0000, 32'h0000_0000};

    for (int i = 0; i < 12; i++) begin
      wr(tbl[i].idx, tbl[i].wd);
      rdreg(tbl[i].idx, v);
      chk($sformatf("tbl%0d", i), v, tbl[i].exp);
    end

    // Rising edge on pin 0 to pending and irq
    wr(REG_RISE_EN, 32'h01);
    wr(REG_IRQ_EN, 32'h01);
    pad_i[0] = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    chk("t1_sync_pre", {31'd0, gpio_sync[0]}, 32'd0);
    @(negedge clk);
    chk("t1_sync", {31'd0, gpio_sync[0]}, 32'd1);
    @(negedge clk);
    chk("t1_irq_pre", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("t1_irq", {31'd0, irq}, 32'd1);
    rdreg(REG_PENDING, v);
    chk("t1_pend", v, 32'h01);

    // W1C: zero has no effect, one clears
    wr(REG_PENDING, 32'h00);
    rdreg(REG_PENDING, v);
    chk("t2_pend_w0", v, 32'h01);
    chk("t2_irq_w0", {31'd0, irq}, 32'd1);
    wr(REG_PENDING, 32'h01);
    chk("t2_irq_rdy", {31'd0, irq}, 32'd1);
    @(negedge clk);
    chk("t2_irq_clr", {31'd0, irq}, 32'd0);
    rdreg(REG_PENDING, v);
    chk("t2_pend_clr", v, 32'h00);

    // Set beats same-cycle clear on pin 7
    wr(REG_FALL_EN, 32'h80);
    pad_i[7] = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    pad_i[7] = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    rdreg(REG_PENDING, v);
    chk("t3_pend_first", v, 32'h80);
    pad_i[7] = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    pad_i[7] = 1'b0;
    repeat (LAT) @(negedge clk);
    wr(REG_PENDING, 32'h80);
    rdreg(REG_PENDING, v);
    chk("t3_set_wins", v, 32'h80);
    wr(REG_PENDING, 32'h80);
    rdreg(REG_PENDING, v);
    chk("t3_clear", v, 32'h00);

    // Polling with irq disabled, then enabling
    wr(REG_IRQ_EN, 32'h00);
    wr(REG_PENDING, 32'hFF);
    wr(REG_RISE_EN, 32'h08);
    pad_i[3] = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    chk("t4_irq_off", {31'd0, irq}, 32'd0);
    rdreg(REG_PENDING, v);
    chk("t4_pend", v, 32'h08);
    wr(REG_IRQ_EN, 32'h08);
    chk("t4_irq_rdy", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("t4_irq_on", {31'd0, irq}, 32'd1);

    // Held valid gives one ready pulse; reset aborts an access
    pad_i = 8'h5A;
    repeat (LAT + 1) @(negedge clk);
    valid = 1'b1; wen = 1'b0; addr = {19'd0, REG_IN, 2'd0};
    npulse = 0;
    @(negedge clk);
    if (ready) npulse++;
    chk("t5_rdata", rdata, 32'h5A);
    @(negedge clk);
    if (ready) npulse++;
    chk("t5_rdata_zero", rdata, 32'h0);
    valid = 1'b0;
    @(negedge clk);
    if (ready) npulse++;
    chk("t5_pulses", npulse, 32'd1);
    valid = 1'b1;
    @(negedge clk);
    chk("t5_rdy_before_rst", {31'd0, ready}, 32'd1);
    #1 resetn = 1'b0;
    #1;
    chk("t5_rst_ready", {31'd0, ready}, 32'd0);
    chk("t5_rst_rdata", rdata, 32'd0);
    chk("t5_rst_irq", {31'd0, irq}, 32'd0);
    valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    rdreg(REG_IRQ_EN, v);
    chk("t5_ien_after_rst", v, 32'h0);

    // Random pads and bus traffic against the model
    chk_on = 1'b1;
    for (int r = 0; r < 8; r++) begin
      wr(REG_RISE_EN, $urandom);
      wr(REG_FALL_EN, $urandom);
      wr(REG_IRQ_EN, $urandom);
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 2) == 0) pad_i = pad_i ^ 8'($urandom);
        case ($urandom_range(0, 9))
          0, 1: rdreg(3'($urandom), v);
          2:    wr(REG_PENDING, $urandom);
          default: @(negedge clk);
        endcase
      end
    end
    repeat (LAT + 3) @(negedge clk);
    chk_on = 1'b0;

`ifdef GPIO_IRQ_DEBOUNCE_EN
    // Debounce: short glitch ignored, long pulse passes after limit
    wr(REG_FALL_EN, 32'h00);
    wr(REG_RISE_EN, 32'h04);
    wr(REG_DB_LIMIT, 32'd4);
    pad_i[2] = 1'b0;
    repeat (20) @(negedge clk);
    wr(REG_PENDING, 32'hFF);
    pad_i[2] = 1'b1;
    repeat (3) @(negedge clk);
    pad_i[2] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      seen = seen | gpio_sync[2];
    end
    chk("t6_glitch_sync", {31'd0, seen}, 32'd0);
    rdreg(REG_PENDING, v);
    chk("t6_glitch_pend", v & 32'h04, 32'h0);
    pad_i[2] = 1'b1;
    repeat (SD + 4) @(negedge clk);
    chk("t6_pulse_pre", {31'd0, gpio_sync[2]}, 32'd0);
    @(negedge clk);
    chk("t6_pulse", {31'd0, gpio_sync[2]}, 32'd1);
    repeat (3) @(negedge clk);
    pad_i[2] = 1'b0;
    repeat (4) @(negedge clk);
    rdreg(REG_PENDING, v);
    chk("t6_pulse_pend", v & 32'h04, 32'h04);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
